page_reader: RTL

- Read-side engine for the packet scheduler page store, a single-clock simple dual-port RAM with 1-cycle registered read.
- Accepts a read command (start word address, length), walks the page RAM read port, and absorbs the RAM read latency.
- Emits the page contents as a valid/ready stream with sop/eop framing.
- Sits between the scheduler's dequeue logic and the egress stream. It only reads; the write port belongs to the page writer.

---
 rtl/page_reader.sv | 92 +++++++++
 1 files changed

// File: rtl/page_reader.sv
// page_reader: streams a packet out of the page RAM as sop/eop framed beats,
// hiding the one-cycle registered read latency behind a two-entry output buffer.
module page_reader #(
    parameter int DATA_WIDTH = 40,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  busy,
    output logic                  err_zero_len
);
    typedef enum logic {IDLE, READ} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  first, inflight, tag_sop, tag_eop;
    logic [DATA_WIDTH-1:0] sk_data;
    logic                  sk_sop, sk_eop, sk_valid;
    logic                  accept, pop, issue;
    logic [1:0]            level;
    assign cmd_ready   = state == IDLE;
    assign accept      = cmd_valid && cmd_ready;
    assign pop         = out_valid && out_ready;
    // Occupancy the buffer would reach if nothing more is issued; never exceeds 2.
    assign level       = 2'(out_valid) + 2'(sk_valid) + 2'(inflight) - 2'(pop);
    assign issue       = state == READ && level < 2'd2;
    assign ram_rd_addr = addr;
    assign busy        = state != IDLE || out_valid || inflight;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            first        <= 1'b0;
            inflight     <= 1'b0;
            tag_sop      <= 1'b0;
            tag_eop      <= 1'b0;
            out_data     <= '0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_valid    <= 1'b0;
            sk_data      <= '0;
            sk_sop       <= 1'b0;
            sk_eop       <= 1'b0;
            sk_valid     <= 1'b0;
            err_zero_len <= 1'b0;
        end else begin
            err_zero_len <= accept && cmd_len == '0;
            inflight     <= issue;
            if (accept && cmd_len != '0) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
                first     <= 1'b1;
                state     <= READ;
            end
            if (issue) begin
                tag_sop   <= first;
                tag_eop   <= remaining == LEN_WIDTH'(1);
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_WIDTH'(1);
                first     <= 1'b0;
                if (remaining == LEN_WIDTH'(1))
                    state <= IDLE;
            end
            // Head register refills from the skid entry first, then from the RAM.
            if (pop || !out_valid) begin
                if (sk_valid)
                    {out_data, out_sop, out_eop} <= {sk_data, sk_sop, sk_eop};
                else if (inflight)
                    {out_data, out_sop, out_eop} <= {ram_q, tag_sop, tag_eop};
                out_valid <= sk_valid || inflight;
                sk_valid  <= sk_valid && inflight;
            end else if (inflight) begin
                sk_valid <= 1'b1;
            end
            if (inflight)
                {sk_data, sk_sop, sk_eop} <= {ram_q, tag_sop, tag_eop};
        end
    end
endmodule
